// File: rtl/gerenciador_contexto.sv
// rtl/gerenciador_contexto.sv - context-switch responder with round-robin ready-slot scan (option: GERENCIADOR_ESTATISTICA_EN)
module gerenciador_contexto #(
    parameter int          NUM_PROC  = 8,
    parameter int          ID_W      = 3,
    parameter int          PC_W      = 32,
    parameter int unsigned PC_OCIOSO = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            troca_req,
    input  logic [PC_W-1:0] pc_salvo,
    input  logic            fim_processo,
    input  logic            cria_req,
    input  logic [ID_W-1:0] cria_id,
    input  logic [PC_W-1:0] cria_pc,
    output logic            cria_ack,
    output logic            troca_ack,
    output logic [PC_W-1:0] pc_restaurado,
    output logic [ID_W-1:0] processo_atual,
    output logic            nenhum_pronto,
    output logic            ocupado
`ifdef GERENCIADOR_ESTATISTICA_EN
    ,
    output logic [15:0]     total_trocas
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        SALVA,
        BUSCA,
        ENTREGA,
        ESPERA
    } estado_t;

    localparam logic [ID_W-1:0] ULTIMO_TESTE = ID_W'(NUM_PROC - 1);

    estado_t             estado;
    estado_t             proxEstado;

    logic [PC_W-1:0]     tabelaPc [NUM_PROC];
    logic [NUM_PROC-1:0] pronto;
    logic [ID_W-1:0]     idx;
    logic [ID_W-1:0]     testes;

    logic                aceitaCria;
    logic                salvaPc;
    logic                achou;
    logic                esgotou;
    logic                avanca;

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= IDLE;
        end else begin
            estado <= proxEstado;
        end
    end

    // next-state and per-state datapath strobes
    always_comb begin
        proxEstado = estado;
        aceitaCria = 1'b0;
        salvaPc    = 1'b0;
        achou      = 1'b0;
        esgotou    = 1'b0;
        avanca     = 1'b0;
        case (estado)
            IDLE: begin
                if (cria_req) begin
                    aceitaCria = 1'b1;
                end else if (troca_req) begin
                    proxEstado = SALVA;
                end
            end
            SALVA: begin
                salvaPc    = 1'b1;
                proxEstado = BUSCA;
            end
            BUSCA: begin
                if (pronto[idx]) begin
                    achou      = 1'b1;
                    proxEstado = ENTREGA;
                end else if (testes == ULTIMO_TESTE) begin
                    // the current slot was the last one tested: nothing runnable
                    esgotou    = 1'b1;
                    proxEstado = ENTREGA;
                end else begin
                    avanca = 1'b1;
                end
            end
            ENTREGA: begin
                proxEstado = ESPERA;
            end
            ESPERA: begin
                // a create is still served here; the CPU may hold troca_req meanwhile
                if (cria_req) begin
                    aceitaCria = 1'b1;
                end else if (!troca_req) begin
                    proxEstado = IDLE;
                end
            end
            default: begin
                proxEstado = IDLE;
            end
        endcase
    end

    // process table, ready bits, scan pointer and registered results
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PROC; i++) begin
                tabelaPc[i] <= '0;
            end
            pronto         <= '0;
            idx            <= '0;
            testes         <= '0;
            cria_ack       <= 1'b0;
            pc_restaurado  <= '0;
            processo_atual <= '0;
            nenhum_pronto  <= 1'b0;
        end else begin
            cria_ack <= aceitaCria;
            if (aceitaCria) begin
                tabelaPc[cria_id] <= cria_pc;
                pronto[cria_id]   <= 1'b1;
            end
            if (salvaPc) begin
                tabelaPc[processo_atual] <= pc_salvo;
                if (fim_processo) begin
                    pronto[processo_atual] <= 1'b0;
                end
                // scan starts just after the current slot, which is tested last
                idx    <= processo_atual + 1'b1;
                testes <= '0;
            end
            if (achou) begin
                pc_restaurado  <= tabelaPc[idx];
                processo_atual <= idx;
                nenhum_pronto  <= 1'b0;
            end
            if (esgotou) begin
                pc_restaurado <= PC_W'(PC_OCIOSO);
                nenhum_pronto <= 1'b1;
            end
            if (avanca) begin
                idx    <= idx + 1'b1;
                testes <= testes + 1'b1;
            end
        end
    end

    // decoded from state so an asynchronous reset drops them at once
    assign troca_ack = (estado == ENTREGA);
    assign ocupado   = (estado != IDLE);

`ifdef GERENCIADOR_ESTATISTICA_EN
    // saturating count of delivered switches
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            total_trocas <= '0;
        end else if (estado == ENTREGA && total_trocas != 16'hFFFF) begin
            total_trocas <= total_trocas + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gerenciador_contexto.sv
// tb/tb_gerenciador_contexto.sv - directed bench for gerenciador_contexto
module tb_gerenciador_contexto;

    logic        clock;
    logic        reset;
    logic        troca_req;
    logic [31:0] pc_salvo;
    logic        fim_processo;
    logic        cria_req;
    logic [2:0]  cria_id;
    logic [31:0] cria_pc;
    logic        cria_ack;
    logic        troca_ack;
    logic [31:0] pc_restaurado;
    logic [2:0]  processo_atual;
    logic        nenhum_pronto;
    logic        ocupado;
`ifdef GERENCIADOR_ESTATISTICA_EN
    logic [15:0] total_trocas;
`endif

    int nTests = 0;
    int nFail  = 0;

    gerenciador_contexto dut (
        .clock          (clock),
        .reset          (reset),
        .troca_req      (troca_req),
        .pc_salvo       (pc_salvo),
        .fim_processo   (fim_processo),
        .cria_req       (cria_req),
        .cria_id        (cria_id),
        .cria_pc        (cria_pc),
        .cria_ack       (cria_ack),
        .troca_ack      (troca_ack),
        .pc_restaurado  (pc_restaurado),
        .processo_atual (processo_atual),
        .nenhum_pronto  (nenhum_pronto),
        .ocupado        (ocupado)
`ifdef GERENCIADOR_ESTATISTICA_EN
        ,
        .total_trocas   (total_trocas)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic criaSlot(input logic [2:0] id, input logic [31:0] pc, output logic acked);
        @(negedge clock);
        cria_req = 1'b1;
        cria_id  = id;
        cria_pc  = pc;
        @(posedge clock);
        #1;
        acked = cria_ack;
        @(negedge clock);
        cria_req = 1'b0;
    endtask

    task automatic iniciaTroca(input logic [31:0] pc, input logic fim);
        @(negedge clock);
        troca_req    = 1'b1;
        pc_salvo     = pc;
        fim_processo = fim;
    endtask

    // edges counted from the edge that samples troca_req; 99 on timeout
    task automatic esperaAck(output int edges);
        edges = 99;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock);
            #1;
            if (troca_ack) begin
                edges = n;
                return;
            end
        end
    endtask

    task automatic liberaTroca();
        @(negedge clock);
        troca_req    = 1'b0;
        fim_processo = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
    endtask

    task automatic trocaCompleta(input logic [31:0] pc, input logic fim, output int edges,
                                 output logic [31:0] pcOut, output logic [2:0] idOut, output logic nenhum);
        iniciaTroca(pc, fim);
        esperaAck(edges);
        pcOut  = pc_restaurado;
        idOut  = processo_atual;
        nenhum = nenhum_pronto;
        liberaTroca();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        nTests++;
        if ({cria_ack, troca_ack, pc_restaurado, processo_atual, nenhum_pronto, ocupado} !== 39'd0) begin
            nFail++;
            $display("FAIL reset_outputs: got ack=%b tack=%b pc=%h id=%0d np=%b oc=%b, want all 0",
                     cria_ack, troca_ack, pc_restaurado, processo_atual, nenhum_pronto, ocupado);
        end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        logic a0, a2, np;
        int e;
        logic [31:0] p;
        logic [2:0] id;
        criaSlot(3'd0, 32'h10, a0);
        criaSlot(3'd2, 32'h40, a2);
        nTests++;
        if ({a0, a2} !== 2'b11) begin
            nFail++;
            $display("FAIL basic_cria_ack: got %b%b, want 11", a0, a2);
        end
        trocaCompleta(32'h15, 1'b0, e, p, id, np);
        nTests++;
        if (e !== 4 || p !== 32'h40 || id !== 3'd2 || np !== 1'b0) begin
            nFail++;
            $display("FAIL basic_troca: got edges=%0d pc=%h id=%0d np=%b, want 4 40 2 0", e, p, id, np);
        end
        nTests++;
        if (ocupado !== 1'b0) begin
            nFail++;
            $display("FAIL basic_idle: got ocupado=%b, want 0", ocupado);
        end
    endtask

    task automatic test_wrap();
        logic np;
        int e;
        logic [31:0] p;
        logic [2:0] id;
        trocaCompleta(32'h47, 1'b0, e, p, id, np);
        nTests++;
        if (e !== 8 || p !== 32'h15 || id !== 3'd0 || np !== 1'b0) begin
            nFail++;
            $display("FAIL wrap_troca: got edges=%0d pc=%h id=%0d np=%b, want 8 15 0 0", e, p, id, np);
        end
        trocaCompleta(32'h20, 1'b0, e, p, id, np);
        nTests++;
        if (e !== 4 || p !== 32'h47 || id !== 3'd2) begin
            nFail++;
            $display("FAIL wrap_saved_pc: got edges=%0d pc=%h id=%0d, want 4 47 2", e, p, id);
        end
    endtask

    task automatic test_ocioso();
        logic np, a;
        int e;
        logic [31:0] p;
        logic [2:0] id;
        trocaCompleta(32'h50, 1'b1, e, p, id, np);
        nTests++;
        if (e !== 8 || p !== 32'h20 || id !== 3'd0) begin
            nFail++;
            $display("FAIL ocioso_drop2: got edges=%0d pc=%h id=%0d, want 8 20 0", e, p, id);
        end
        trocaCompleta(32'h99, 1'b1, e, p, id, np);
        nTests++;
        if (e !== 10 || p !== 32'h1 || id !== 3'd0 || np !== 1'b1) begin
            nFail++;
            $display("FAIL ocioso_none: got edges=%0d pc=%h id=%0d np=%b, want 10 1 0 1", e, p, id, np);
        end
        criaSlot(3'd0, 32'h30, a);
        trocaCompleta(32'h33, 1'b0, e, p, id, np);
        nTests++;
        if (e !== 10 || p !== 32'h33 || id !== 3'd0 || np !== 1'b0) begin
            nFail++;
            $display("FAIL ocioso_reselect: got edges=%0d pc=%h id=%0d np=%b, want 10 33 0 0", e, p, id, np);
        end
    endtask

    task automatic test_prioridade();
        logic a, oc;
        int e, acks;
        @(negedge clock);
        cria_req     = 1'b1;
        cria_id      = 3'd5;
        cria_pc      = 32'h55;
        troca_req    = 1'b1;
        pc_salvo     = 32'h34;
        fim_processo = 1'b0;
        @(posedge clock);
        #1;
        a  = cria_ack;
        oc = ocupado;
        @(negedge clock);
        cria_req = 1'b0;
        esperaAck(e);
        nTests++;
        if (a !== 1'b1 || oc !== 1'b0 || e !== 7 || pc_restaurado !== 32'h55 || processo_atual !== 3'd5) begin
            nFail++;
            $display("FAIL prio_cria_first: got ack=%b oc=%b edges=%0d pc=%h id=%0d, want 1 0 7 55 5",
                     a, oc, e, pc_restaurado, processo_atual);
        end
        liberaTroca();
        // create attempted while scanning must be ignored
        iniciaTroca(32'h56, 1'b0);
        acks = 0;
        e = 99;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clock);
            #1;
            if (cria_ack) acks++;
            if (n == 2) begin
                @(negedge clock);
                cria_req = 1'b1;
                cria_id  = 3'd3;
                cria_pc  = 32'h77;
            end
            if (troca_ack) begin
                e = n;
                break;
            end
        end
        @(negedge clock);
        cria_req = 1'b0;
        nTests++;
        if (acks !== 0 || e !== 5 || pc_restaurado !== 32'h34 || processo_atual !== 3'd0) begin
            nFail++;
            $display("FAIL prio_busca_ignored: got acks=%0d edges=%0d pc=%h id=%0d, want 0 5 34 0",
                     acks, e, pc_restaurado, processo_atual);
        end
        liberaTroca();
    endtask

    task automatic test_espera();
        int e, acks, busyLow;
        iniciaTroca(32'h35, 1'b0);
        esperaAck(e);
        nTests++;
        if (e !== 7 || pc_restaurado !== 32'h56 || processo_atual !== 3'd5) begin
            nFail++;
            $display("FAIL espera_troca: got edges=%0d pc=%h id=%0d, want 7 56 5 (slot 3 skipped)",
                     e, pc_restaurado, processo_atual);
        end
        acks = 0;
        busyLow = 0;
        repeat (5) begin
            @(posedge clock);
            #1;
            if (troca_ack) acks++;
            if (!ocupado) busyLow++;
        end
        nTests++;
        if (acks !== 0 || busyLow !== 0) begin
            nFail++;
            $display("FAIL espera_hold: got extra acks=%0d idle cycles=%0d, want 0 0", acks, busyLow);
        end
        @(negedge clock);
        troca_req = 1'b0;
        @(posedge clock);
        #1;
        nTests++;
        if (ocupado !== 1'b0) begin
            nFail++;
            $display("FAIL espera_release: got ocupado=%b, want 0", ocupado);
        end
    endtask

    task automatic test_reset_busca();
        logic np;
        int e;
        logic [31:0] p;
        logic [2:0] id;
`ifdef GERENCIADOR_ESTATISTICA_EN
        nTests++;
        if (total_trocas !== 16'd9) begin
            nFail++;
            $display("FAIL stat_before_reset: got %0d, want 9", total_trocas);
        end
`endif
        iniciaTroca(32'h60, 1'b0);
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        nTests++;
        if ({troca_ack, ocupado, pc_restaurado, processo_atual, nenhum_pronto} !== 38'd0) begin
            nFail++;
            $display("FAIL reset_busca_async: got tack=%b oc=%b pc=%h id=%0d np=%b, want all 0",
                     troca_ack, ocupado, pc_restaurado, processo_atual, nenhum_pronto);
        end
`ifdef GERENCIADOR_ESTATISTICA_EN
        nTests++;
        if (total_trocas !== 16'd0) begin
            nFail++;
            $display("FAIL stat_reset: got %0d, want 0", total_trocas);
        end
`endif
        troca_req = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        trocaCompleta(32'h61, 1'b0, e, p, id, np);
        nTests++;
        if (e !== 10 || p !== 32'h1 || np !== 1'b1 || id !== 3'd0) begin
            nFail++;
            $display("FAIL reset_ready_cleared: got edges=%0d pc=%h np=%b id=%0d, want 10 1 1 0", e, p, np, id);
        end
        trocaCompleta(32'h62, 1'b0, e, p, id, np);
        trocaCompleta(32'h63, 1'b0, e, p, id, np);
`ifdef GERENCIADOR_ESTATISTICA_EN
        nTests++;
        if (total_trocas !== 16'd3) begin
            nFail++;
            $display("FAIL stat_three: got %0d, want 3", total_trocas);
        end
`endif
    endtask

    initial begin
        reset        = 1'b0;
        troca_req    = 1'b0;
        pc_salvo     = '0;
        fim_processo = 1'b0;
        cria_req     = 1'b0;
        cria_id      = '0;
        cria_pc      = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_ocioso();
        test_prioridade();
        test_espera();
        test_reset_busca();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/gerenciador_contexto.md
Name: gerenciador_contexto

Overview:
- Responder side of the CPU's context-switch interface.
- When the CPU requests a context switch, this block:
  - stores the preempted process's PC in a per-process table;
  - picks the next ready process round-robin;
  - returns that process's PC and ID with an acknowledge pulse.
- The OS/BIOS loads process entries through a separate create port. The block sits between the quantum counter/CPU and the PC-select mux.

Parameters:
- NUM_PROC, 8, number of process slots (power of 2, at least 2).
- ID_W, 3, process-ID width, equal to log2(NUM_PROC).
- PC_W, 32, PC width.
- PC_OCIOSO, 1, PC returned when no process is ready (scheduler address).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- troca_req  in  1  context-switch request from CPU; level signal, held until troca_ack.
- pc_salvo  in  PC_W  PC of the preempted process; valid while troca_req=1.
- fim_processo  in  1  current process finished; sampled with troca_req.
- cria_req  in  1  load/create a process entry.
- cria_id  in  ID_W  slot to load.
- cria_pc  in  PC_W  start PC for that slot.
- cria_ack  out  1  one-cycle pulse when the create is accepted.
- troca_ack  out  1  one-cycle pulse; pc_restaurado and processo_atual are valid.
- pc_restaurado  out  PC_W  PC of the next process.
- processo_atual  out  ID_W  ID of the running process.
- nenhum_pronto  out  1  registered; set when the last switch found no ready slot.
- ocupado  out  1  high in any state other than IDLE.

Behaviour:
- Storage: tabela_pc[NUM_PROC] of PC_W bits, plus a ready bit per slot.
- Reset (reset=0, async): all table entries and ready bits are 0. All outputs are 0. State is IDLE. Asserting reset mid-operation aborts immediately, and troca_ack drops the same instant.
- FSM states:
  - IDLE: if cria_req=1, write tabela_pc[cria_id]=cria_pc, set ready[cria_id]=1, pulse cria_ack next cycle, stay IDLE. Else if troca_req=1, go to SALVA. Create has priority over a simultaneous troca_req; the troca is taken on the following edge.
  - SALVA: write tabela_pc[processo_atual]=pc_salvo. If fim_processo=1, clear ready[processo_atual]. Set idx=(processo_atual+1) mod NUM_PROC, then go to BUSCA.
  - BUSCA: at each edge, test ready[idx].
    - If set: register pc_restaurado=tabela_pc[idx], processo_atual=idx, nenhum_pronto=0, then go to ENTREGA.
    - Else: idx increments with wrap-around.
    - After NUM_PROC misses (the current slot is tested last): pc_restaurado=PC_OCIOSO, nenhum_pronto=1, processo_atual unchanged, then go to ENTREGA.
  - ENTREGA: troca_ack=1 for exactly one cycle, then go to ESPERA.
  - ESPERA: wait for troca_req=0, then go to IDLE. cria_req is accepted here with the same rule as IDLE.
- cria_req in SALVA, BUSCA or ENTREGA is ignored (no cria_ack). The requester must hold it.
- Latency: troca_req sampled at edge E0 gives troca_ack high during the cycle after edge E(1+k), where k = slot distance (1..NUM_PROC).
- If the only ready process is the current one, it is re-selected with its just-saved PC (k=NUM_PROC).
- pc_restaurado and processo_atual hold their values between switches.

Optional Feature:
- Macro: GERENCIADOR_ESTATISTICA_EN.
- Defined: adds output total_trocas [15:0]. It increments on every troca_ack, saturates at 16'hFFFF, and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then create slot 0 pc=0x10 and slot 2 pc=0x40; troca_req with pc_salvo=0x15 -> cria_ack pulses; troca_ack high after edge 3 with pc_restaurado=0x40, processo_atual=2, nenhum_pronto=0.
- Next troca_req with pc_salvo=0x47 -> wraps to slot 0; pc_restaurado=0x15, processo_atual=0; tabela_pc[2]=0x47 verified via a later switch.
- Only slot 0 ready, troca_req with fim_processo=1 -> after 8 scan edges, pc_restaurado=1, nenhum_pronto=1, processo_atual=0.
- cria_req and troca_req both asserted in IDLE -> create is served first (cria_ack), switch completes afterwards; cria_req during BUSCA gets no cria_ack.
- Hold troca_req high after ack -> exactly one troca_ack and ocupado stays 1 (ESPERA) until req drops; then ocupado=0.
- reset asserted during BUSCA -> outputs 0 asynchronously, ready bits cleared. With GERENCIADOR_ESTATISTICA_EN: 3 switches give total_trocas=3, and reset returns it to 0.
